// File: rtl/bsg_gray_ptr_credit_counter.sv
// bsg_gray_ptr_credit_counter
// Consumer-side stage after a gray-pointer synchronizer. It converts the
// synchronized gray pointer to binary, measures how far the pointer advanced
// since the previous sample, accumulates the advances as credits (saturating,
// with a sticky overflow flag) and releases one credit per yumi.
// Optional build macro: BSG_GRAY_CREDIT_IN_REG_EN adds an input register on
// ptr_gray_i, which adds one cycle of pointer-to-credit latency.

module bsg_gray_ptr_credit_counter #(
    parameter int ptr_width_p    = 8,
    parameter int credit_width_p = 8,
    parameter int init_credits_p = 0
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic [ptr_width_p-1:0]    ptr_gray_i,
    output logic [ptr_width_p-1:0]    ptr_bin_o,
    output logic [credit_width_p-1:0] credits_o,
    output logic                      v_o,
    input  logic                      yumi_i,
    output logic                      overflow_o
);

    localparam logic [credit_width_p-1:0] init_credits_lp = credit_width_p'(init_credits_p);
    localparam logic                      init_v_lp       = (init_credits_p != 0);

    // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
    function automatic logic [ptr_width_p-1:0] gray_to_bin(input logic [ptr_width_p-1:0] g);
        logic [ptr_width_p-1:0] b;
        b[ptr_width_p-1] = g[ptr_width_p-1];
        for (int i = ptr_width_p - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [ptr_width_p-1:0]    gray_s;
    logic [ptr_width_p-1:0]    bin_s;
    logic [ptr_width_p-1:0]    delta_s;
    logic [credit_width_p:0]   sum_s;
    logic                      yumi_eff_s;
    logic [credit_width_p-1:0] credits_nxt_s;
    logic                      overflow_nxt_s;

    logic [ptr_width_p-1:0]    ptr_r;
    logic [credit_width_p-1:0] credits_r;
    logic                      v_r;
    logic                      overflow_r;

`ifdef BSG_GRAY_CREDIT_IN_REG_EN
    logic [ptr_width_p-1:0] g_r;

    // Input register decouples the converter from the synchronizer flop.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            g_r <= '0;
        end else begin
            g_r <= ptr_gray_i;
        end
    end

    assign gray_s = g_r;
`else
    assign gray_s = ptr_gray_i;
`endif

    // Pointer advance and credit accumulation; sum is one bit wider so saturation is visible.
    always_comb begin
        bin_s          = gray_to_bin(gray_s);
        delta_s        = bin_s - ptr_r;
        yumi_eff_s     = yumi_i & v_r;
        sum_s          = {1'b0, credits_r}
                       + {{(credit_width_p + 1 - ptr_width_p){1'b0}}, delta_s}
                       - {{credit_width_p{1'b0}}, yumi_eff_s};
        credits_nxt_s  = sum_s[credit_width_p-1:0];
        overflow_nxt_s = overflow_r;
        if (sum_s[credit_width_p]) begin
            credits_nxt_s  = {credit_width_p{1'b1}};
            overflow_nxt_s = 1'b1;
        end else begin
            credits_nxt_s  = sum_s[credit_width_p-1:0];
            overflow_nxt_s = overflow_r;
        end
    end

    // State registers; v is registered alongside credits so it never depends on inputs.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            ptr_r      <= '0;
            credits_r  <= init_credits_lp;
            v_r        <= init_v_lp;
            overflow_r <= 1'b0;
        end else begin
            ptr_r      <= bin_s;
            credits_r  <= credits_nxt_s;
            v_r        <= (credits_nxt_s != {credit_width_p{1'b0}});
            overflow_r <= overflow_nxt_s;
        end
    end

    assign ptr_bin_o  = ptr_r;
    assign credits_o  = credits_r;
    assign v_o        = v_r;
    assign overflow_o = overflow_r;

    bsg_gray_ptr_credit_counter_chk chk (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .yumi_i    (yumi_i),
        .v_i       (v_r)
    );

endmodule

// Protocol checker: a yumi must only be presented while a credit is available.
module bsg_gray_ptr_credit_counter_chk (
    input logic clk_i,
    input logic reset_n_i,
    input logic yumi_i,
    input logic v_i
);

    yumi_needs_credit_a: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_i)
        else $error("yumi_i asserted with no credit available");

endmodule

// File: tb/tb_bsg_gray_ptr_credit_counter.sv
// Self-checking bench for bsg_gray_ptr_credit_counter: two instances (8-bit
// pointer/credits with init 4, and 4-bit pointer/credits with init 12 for
// saturation), an arithmetic reference model, a per-cycle compare process and
// directed literal checks. Honours BSG_GRAY_CREDIT_IN_REG_EN for latency.

module tb_bsg_gray_ptr_credit_counter;

`ifdef BSG_GRAY_CREDIT_IN_REG_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif

    localparam int P[2]    = '{8, 4};
    localparam int C[2]    = '{8, 4};
    localparam int INIT[2] = '{4, 12};

    logic       clk = 1'b0;
    logic       rst_n[2];
    logic [7:0] gray[2];
    logic       yumi[2];

    logic [7:0] pb0, cr0;
    logic       v0, of0;
    logic [3:0] pb1, cr1;
    logic       v1, of1;

    int checks = 0;
    int errors = 0;
    int ncyc   = 0;

    int m_cred[2];
    int m_ptr[2];
    int m_g[2];
    bit m_ovf[2];

    always #5 clk = ~clk;

    bsg_gray_ptr_credit_counter #(.ptr_width_p(8), .credit_width_p(8), .init_credits_p(4)) dut0 (
        .clk_i(clk), .reset_n_i(rst_n[0]), .ptr_gray_i(gray[0]), .ptr_bin_o(pb0),
        .credits_o(cr0), .v_o(v0), .yumi_i(yumi[0]), .overflow_o(of0)
    );

    bsg_gray_ptr_credit_counter #(.ptr_width_p(4), .credit_width_p(4), .init_credits_p(12)) dut1 (
        .clk_i(clk), .reset_n_i(rst_n[1]), .ptr_gray_i(gray[1][3:0]), .ptr_bin_o(pb1),
        .credits_o(cr1), .v_o(v1), .yumi_i(yumi[1]), .overflow_o(of1)
    );

    // Binary value whose gray code equals g, found by search.
    function automatic int g2b(input int g, input int p);
        for (int b = 0; b < (1 << p); b++) begin
            if ((b ^ (b >> 1)) == g) return b;
        end
        return 0;
    endfunction

    function automatic int raw_sum(input int cred, input int ptr, input int g, input bit y, input int p);
        int d;
        d = (g2b(g, p) - ptr + (1 << p)) % (1 << p);
        return cred + d - ((y && cred != 0) ? 1 : 0);
    endfunction

    // Reference model: advances once per clock from the inputs seen at that edge.
    always @(posedge clk) begin
        ncyc <= ncyc + 1;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n[k]) begin
                m_g[k]    <= 0;
                m_ptr[k]  <= 0;
                m_cred[k] <= INIT[k];
                m_ovf[k]  <= 1'b0;
            end else begin
                m_g[k]    <= int'(gray[k]);
                m_ptr[k]  <= g2b((L == 2) ? m_g[k] : int'(gray[k]), P[k]);
                m_cred[k] <= (raw_sum(m_cred[k], m_ptr[k], (L == 2) ? m_g[k] : int'(gray[k]), yumi[k], P[k]) > (1 << C[k]) - 1)
                             ? (1 << C[k]) - 1
                             : raw_sum(m_cred[k], m_ptr[k], (L == 2) ? m_g[k] : int'(gray[k]), yumi[k], P[k]);
                m_ovf[k]  <= m_ovf[k] | (raw_sum(m_cred[k], m_ptr[k], (L == 2) ? m_g[k] : int'(gray[k]), yumi[k], P[k]) > (1 << C[k]) - 1);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (ncyc > 0) begin
            chk("m0_ptr", int'(pb0), m_ptr[0]);
            chk("m0_cred", int'(cr0), m_cred[0]);
            chk("m0_v", int'(v0), int'(m_cred[0] != 0));
            chk("m0_ovf", int'(of0), int'(m_ovf[0]));
            chk("m1_ptr", int'(pb1), m_ptr[1]);
            chk("m1_cred", int'(cr1), m_cred[1]);
            chk("m1_v", int'(v1), int'(m_cred[1] != 0));
            chk("m1_ovf", int'(of1), int'(m_ovf[1]));
        end
    end

    task automatic step(input int k, input int g, input bit y);
        gray[k] = 8'(g);
        yumi[k] = y;
        @(negedge clk);
        yumi[k] = 1'b0;
    endtask

    task automatic settle(input int k);
        repeat (L - 1) step(k, int'(gray[k]), 1'b0);
    endtask

    initial begin
        rst_n[0] = 1'b0; rst_n[1] = 1'b0;
        gray[0]  = 8'h00; gray[1] = 8'h00;
        yumi[0]  = 1'b0;  yumi[1] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;

        // Reset values
        chk("rst_cred", int'(cr0), 4);
        chk("rst_v", int'(v0), 1);
        chk("rst_ptr", int'(pb0), 0);
        chk("rst_ovf", int'(of0), 0);

        // Single gray steps 00->01->03->02
        step(0, 8'h01, 1'b0); chk("step1_cred", int'(cr0), (L == 1) ? 5 : 4);
        step(0, 8'h03, 1'b0); chk("step2_cred", int'(cr0), (L == 1) ? 6 : 5);
        step(0, 8'h02, 1'b0); chk("step3_cred", int'(cr0), (L == 1) ? 7 : 6);
        chk("step3_ptr", int'(pb0), (L == 1) ? 3 : 2);
        step(0, 8'h02, 1'b0); chk("steps_cred", int'(cr0), 7);
        chk("steps_ptr", int'(pb0), 3);

        // Multi-count jump: binary 3 -> 7 (gray 0x04)
        step(0, 8'h04, 1'b0); settle(0);
        chk("jump_cred", int'(cr0), 11);
        chk("jump_ptr", int'(pb0), 7);

        // Drain to 3, then credit+yumi cancel, then yumi alone
        repeat (8) step(0, 8'h04, 1'b1);
        chk("drain_cred", int'(cr0), 3);
        if (L == 1) begin
            step(0, 8'h0C, 1'b1);
        end else begin
            step(0, 8'h0C, 1'b0);
            step(0, 8'h0C, 1'b1);
        end
        chk("cancel_cred", int'(cr0), 3);
        chk("cancel_ptr", int'(pb0), 8);
        step(0, 8'h0C, 1'b1);
        chk("yumi_cred", int'(cr0), 2);

        // Wrap: 8 -> 255 (gray 0x80) then 255 -> 0
        step(0, 8'h80, 1'b0); settle(0);
        chk("to255_cred", int'(cr0), 249);
        chk("to255_ptr", int'(pb0), 255);
        step(0, 8'h00, 1'b0); settle(0);
        chk("wrap_cred", int'(cr0), 250);
        chk("wrap_ptr", int'(pb0), 0);

        // Mid-operation reset restores the initial credits
        rst_n[0] = 1'b0; @(negedge clk); rst_n[0] = 1'b1;
        chk("rerst_cred", int'(cr0), 4);

        // Saturation on the 4-bit instance
        chk("b_rst_cred", int'(cr1), 12);
        step(1, 8'h02, 1'b0); settle(1);
        chk("b_fill_cred", int'(cr1), 15);
        chk("b_fill_ovf", int'(of1), 0);
        step(1, 8'h05, 1'b0); settle(1);
        chk("b_sat_cred", int'(cr1), 15);
        chk("b_sat_ovf", int'(of1), 1);
        chk("b_sat_ptr", int'(pb1), 6);
        step(1, 8'h05, 1'b1);
        chk("b_yumi_cred", int'(cr1), 14);
        chk("b_yumi_ovf", int'(of1), 1);
        rst_n[1] = 1'b0; gray[1] = 8'h00;
        repeat (2) @(negedge clk);
        rst_n[1] = 1'b1;
        chk("b_rerst_ovf", int'(of1), 0);
        chk("b_rerst_cred", int'(cr1), 12);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
